// File: rtl/rbr_add_subb_arb_if.sv
// ============================================================================
// rbr_add_subb_arb_if : requester, shared-adder and response bundle for the
//                       RBR adder/subtractor arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

interface rbr_add_subb_arb_if #(
  parameter int W   = 64,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       req_subb_a;
  logic [N-1:0]       req_subb_b;
  logic [N*2*W-1:0]   req_a;
  logic [N*2*W-1:0]   req_b;

  logic               add_subb_a;
  logic               add_subb_b;
  logic [2*W-1:0]     add_a;
  logic [2*W-1:0]     add_b;
  logic [2*W-1:0]     add_s;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [2*W-1:0]     rsp_s;

  // Arbiter side
  modport slave (
    input  req_valid, req_subb_a, req_subb_b, req_a, req_b, add_s, rsp_ready,
    output req_ready, add_subb_a, add_subb_b, add_a, add_b,
           rsp_valid, rsp_id, rsp_s
  );

  // Requesters, shared adder and response consumer
  modport master (
    output req_valid, req_subb_a, req_subb_b, req_a, req_b, add_s, rsp_ready,
    input  req_ready, add_subb_a, add_subb_b, add_a, add_b,
           rsp_valid, rsp_id, rsp_s
  );
endinterface

`default_nettype wire

// File: rtl/rbr_add_subb_arb.sv
// ============================================================================
// rbr_add_subb_arb : arbitrates N requesters onto one shared combinational RBR
//                    adder/subtractor through an issue stage and a response stage.
// Option macro RBR_ARB_ROUND_ROBIN_EN: rotating priority (else lowest index wins).
// Revision 1.0
// ============================================================================
`default_nettype none

module rbr_add_subb_arb #(
  parameter int W   = 64,
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  rbr_add_subb_arb_if.slave   bus
);

  localparam int DW = 2 * W;

  logic [IDW-1:0] w_ptr;
  logic [IDW-1:0] w_gidx;
  logic [N-1:0]   w_grant;
  logic [N-1:0]   w_ready;
  logic           w_any;
  logic           w_adv2;
  logic           w_load1;
  logic           w_xfer;

  logic           r_op_valid;
  logic [IDW-1:0] r_op_id;
  logic           r_subb_a;
  logic           r_subb_b;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;

  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [DW-1:0]  r_rsp_s;

  // First valid requester at or after the pointer, wrapping N-1 -> 0
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(w_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_any && bus.req_valid[idx]) begin
        w_any        = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = idx[IDW-1:0];
      end
    end
  end

  assign w_adv2  = r_op_valid & (~r_rsp_valid | bus.rsp_ready);
  assign w_load1 = ~r_op_valid | w_adv2;
  assign w_ready = rst ? '0 : (w_grant & {N{w_load1}});
  assign w_xfer  = |w_ready;

`ifdef RBR_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gidx == IDW'(N - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Issue stage: payload registers only move on an actual transfer so the
  // adder inputs stay quiet while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_op_id    <= '0;
      r_subb_a   <= 1'b0;
      r_subb_b   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (w_load1) begin
      r_op_valid <= w_xfer;
      if (w_xfer) begin
        r_op_id  <= w_gidx;
        r_subb_a <= bus.req_subb_a[w_gidx];
        r_subb_b <= bus.req_subb_b[w_gidx];
        r_a      <= bus.req_a[int'(w_gidx)*DW +: DW];
        r_b      <= bus.req_b[int'(w_gidx)*DW +: DW];
      end
    end
  end

  // Response stage captures the adder result one cycle after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_s     <= '0;
    end else if (w_adv2) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_op_id;
      r_rsp_s     <= bus.add_s;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.add_subb_a = r_subb_a;
  assign bus.add_subb_b = r_subb_b;
  assign bus.add_a      = r_a;
  assign bus.add_b      = r_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_s      = r_rsp_s;

endmodule

`default_nettype wire

// File: tb/tb_rbr_add_subb_arb.sv
// ============================================================================
// tb_rbr_add_subb_arb : directed self-checking bench for rbr_add_subb_arb.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rbr_add_subb_arb;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 2 * W;

`ifdef RBR_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   acc;

  logic [DW-1:0] op_a [N];
  logic [DW-1:0] op_b [N];

  always #5 clk = ~clk;

  rbr_add_subb_arb_if #(.W(W), .N(N), .IDW(IDW)) bus ();

  rbr_add_subb_arb #(.W(W), .N(N), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the shared adder: digit negation modelled as bit inversion
  function automatic logic [DW-1:0] model_add(input logic sa, input logic sb,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    return (sa ? ~a : a) + (sb ? ~b : b);
  endfunction

  assign bus.add_s = model_add(bus.add_subb_a, bus.add_subb_b, bus.add_a, bus.add_b);

  function automatic int exp_grant(input int k);
    return RR ? (k % N) : 0;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = 128'h0123456789ABCDEF_0000000000000010 + DW'(i);
      op_b[i] = DW'(256 * (i + 1));
    end
    op_a[2] = {{63{2'b01}}, 2'b11};
    op_b[2] = {{63{2'b01}}, 2'b11};
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = op_a[i];
      bus.req_b[i*DW +: DW] = op_b[i];
    end
    bus.req_subb_a = '0;
    bus.req_subb_b = '0;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = '1;

    // Reset state, with requests pending during reset
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, '0);
    step();
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_s", bus.rsp_s, '0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_add_a", bus.add_a, '0);
    chk("rst_add_subb_a", bus.add_subb_a, 0);
    step();
    rst = 1'b0;
    bus.req_valid = '0;

    // Single op from requester 2: +1 + +1
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_ready_drop", bus.req_ready, '0);
    chk("single_add_a", bus.add_a, op_a[2]);
    chk("single_rsp_early", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_id", bus.rsp_id, 2);
    chk("single_rsp_s", bus.rsp_s, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAE);
    step();
    @(negedge clk);
    chk("single_rsp_pop", bus.rsp_valid, 0);
    chk("single_add_a_hold", bus.add_a, op_a[2]);

    // All requesters valid, consumer always ready: one op per cycle
    pulse_rst();
    bus.req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stream_ready", bus.req_ready, oh(exp_grant(k)));
      if (k >= 2) begin
        chk("stream_rsp_valid", bus.rsp_valid, 1);
        chk("stream_rsp_id", bus.rsp_id, exp_grant(k - 2));
        chk("stream_rsp_s", bus.rsp_s,
            model_add(1'b0, 1'b0, op_a[exp_grant(k - 2)], op_b[exp_grant(k - 2)]));
      end
      step();
    end
    bus.req_valid = '0;

    // Backpressure: exactly two ops buffered, then acceptance stops
    pulse_rst();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (|bus.req_ready) acc++;
      chk("stall_ready", bus.req_ready, (k < 2) ? oh(exp_grant(k)) : '0);
      step();
    end
    chk("stall_accepted", acc, 2);

    // Single-cycle release while full: pop and new issue on the same edge
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_issue_ready", bus.req_ready, oh(exp_grant(2)));
    chk("pop_issue_rsp_valid", bus.rsp_valid, 1);
    chk("pop_issue_rsp_id", bus.rsp_id, exp_grant(0));
    step();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("refill_rsp_id", bus.rsp_id, exp_grant(1));
    chk("refill_rsp_valid", bus.rsp_valid, 1);
    chk("refill_ready", bus.req_ready, '0);
    chk("refill_add_a", bus.add_a, op_a[exp_grant(2)]);

    // Reset with both stages full discards everything
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.req_ready, '0);
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_s", bus.rsp_s, '0);
    chk("midrst_add_a", bus.add_a, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("midrst_no_stale", bus.rsp_valid, 0);
    end
    step();
    bus.req_valid = '1;
    @(negedge clk);
    chk("midrst_ptr0", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    step();
    step();

    // Negate-a on requester 1
    bus.req_valid  = 4'b0010;
    bus.req_subb_a = 4'b0010;
    bus.req_subb_b = 4'b0000;
    @(negedge clk);
    chk("subb_ready", bus.req_ready, 4'b0010);
    step();
    bus.req_valid  = '0;
    bus.req_subb_a = '0;
    @(negedge clk);
    chk("subb_add_subb_a", bus.add_subb_a, 1);
    chk("subb_add_subb_b", bus.add_subb_b, 0);
    chk("subb_add_a", bus.add_a, op_a[1]);
    step();
    @(negedge clk);
    chk("subb_rsp_id", bus.rsp_id, 1);
    chk("subb_rsp_s", bus.rsp_s, 128'hFEDCBA9876543211_00000000000001EE);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rbr_add_subb_arb.md
# rbr_add_subb_arb

Round-robin arbiter and two-stage issue/response scheduler that shares one combinational RBR adder/subtractor among N requesters in the BKM FPU datapath. The block accepts operand pairs over per-requester valid/ready channels, registers the winner onto the shared adder's inputs, captures the adder's sum one cycle later, and returns it on a single tagged response channel with backpressure.

## Interface
- W, 64, RBR word width in digits; operands and sums are 2*W bits.
- N, 4, number of requesters; N ≥ 2.
- IDW, $clog2(N), response tag width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i presents an operation.
- req_ready  out  N  requester i's operation is accepted this cycle.
- req_subb_a  in  N  per-requester negate-a flag.
- req_subb_b  in  N  per-requester negate-b flag.
- req_a  in  N*2*W  packed operand a; requester i at [i*2*W +: 2*W].
- req_b  in  N*2*W  packed operand b, same packing.
- add_subb_a  out  1  to shared adder, registered.
- add_subb_b  out  1  to shared adder, registered.
- add_a  out  2*W  to shared adder, registered.
- add_b  out  2*W  to shared adder, registered.
- add_s  in  2*W  sum from shared adder (combinational from add_* outputs).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of originating requester.
- rsp_s  out  2*W  RBR result.

## Operation
- Stage 1 (issue): registers op_valid, op_id, add_subb_a, add_subb_b, add_a, add_b.
- Stage 2 (response): registers rsp_valid, rsp_id, rsp_s <= add_s.
- adv2 = op_valid & (~rsp_valid | rsp_ready); stage 2 loads on adv2; rsp_valid clears when rsp_valid & rsp_ready & ~adv2.
- load1 = ~op_valid | adv2; stage 1 loads granted request when load1; op_valid <= |grant when load1.
- grant: combinational one-hot over req_valid, search starts at pointer ptr, wraps N-1 -> 0; zero if no req_valid.
- req_ready = grant & {N{load1}}; transfer on req_valid[i] & req_ready[i]; at most one bit set.
- ptr <= (granted index + 1) mod N on transfer only; unchanged otherwise.
- Payload registers hold value when not loading; data content unspecified while corresponding valid is 0, but held stable (no toggling when idle).
- Simultaneous response pop and new issue: both occur in same cycle; full throughput 1 op/cycle with rsp_ready held high.
- Requester must hold payload stable while req_valid & ~req_ready; block never drops or duplicates an accepted op.
- Reset values: ptr=0, op_valid=0, rsp_valid=0, rsp_id=0, rsp_s=0, add_subb_a=0, add_subb_b=0, add_a=0, add_b=0; req_ready=0 during rst.
- Reset mid-operation: in-flight ops in both stages discarded; no response produced for them.

## Timing
- Accept at edge T -> add_* valid after T; rsp_valid high after edge T+1 (latency 2 cycles), assuming no stall.
- Stall with rsp_ready low: stage 2 holds; stage 1 holds next op; req_ready all 0 once both stages full (2 ops buffered max).
- rsp_ready rising while full: response pops, stage 1 moves to stage 2, new request accepted, same edge.
- Responses return in acceptance order.
- Combinational paths: req_valid -> req_ready and rsp_ready -> req_ready; no path from req_* to rsp_*.

## Configuration
- RBR_ARB_ROUND_ROBIN_EN defined: rotating-priority grant as above.
- Not defined: fixed priority, lowest index wins; ptr removed (treated as 0 constantly); all other behaviour identical.

## Test plan
- Single op: req 2, a=b=all digits 01 except digit0=11 (+1), subb=0 -> rsp at T+2 with rsp_id=2, rsp_s equal to adder result for +1+1; req_ready[2] high one cycle.
- All N valid continuously, rsp_ready=1 (round-robin build): grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches; fixed-priority build: grant always 0.
- rsp_ready low 5 cycles with all requesters valid: exactly 2 ops accepted, then req_ready=0; on release, responses in order, no loss/duplicate.
- Simultaneous pop and issue: full pipeline, rsp_ready=1 single cycle -> one response out, one new acceptance same edge.
- rst asserted with both stages full -> next cycle rsp_valid=0, op_valid=0, ptr=0, rsp_s=0; no stale response after release.
- subb flags: req 1 with subb_a=1, subb_b=0 -> add_subb_a=1, add_subb_b=0 on issue cycle; rsp_s matches digit-negated-a plus b.
